// File: rtl/change_dispenser.sv
// change_dispenser
// Downstream stage of the payment state machine. Latches the amount to give
// back (a full refund for invalid or insufficient money, otherwise change) and
// pays it out coin by coin over a req/ack handshake with the coin hopper,
// always choosing the largest denomination (10, 5, 2, 1) that still fits.
//
// Optional feature: define CHANGE_DISPENSER_TIMEOUT_EN to add a hopper
// watchdog. When enabled, a request left unacknowledged for TIMEOUT_CYCLES
// cycles raises a sticky fault, ends the payout and blocks later payouts until
// reset. When the macro is undefined, fault is tied low and the dispenser waits
// for ack indefinitely.
//
// Ports:
//   clock        system clock, rising edge
//   reset        asynchronous, active-high
//   pay_state    payment FSM code (000 idle, 001 inserted, 010 invalid,
//                011 valid, 100 return)
//   inputMoney   inserted amount
//   valueToPay   price
//   hopper_ack   one-cycle pulse, coin released
//   hopper_req   coin request, held until acked
//   coin_sel     00=1, 01=2, 10=5, 11=10; stable while hopper_req is high
//   busy         amount latched or dispensing
//   done         one-cycle pulse at end of payout
//   refund       latched payout is a full refund
//   underpay     valid money but inputMoney < valueToPay
//   amount_left  remaining units to dispense
//   fault        sticky hopper timeout (0 when the watchdog is compiled out)
module change_dispenser #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int GAP_CYCLES     = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] pay_state,
    input  logic [4:0] inputMoney,
    input  logic [4:0] valueToPay,
    input  logic       hopper_ack,
    output logic       hopper_req,
    output logic [1:0] coin_sel,
    output logic       busy,
    output logic       done,
    output logic       refund,
    output logic       underpay,
    output logic [4:0] amount_left,
    output logic       fault
);

    localparam logic [2:0] PAY_IDLE    = 3'b000;
    localparam logic [2:0] PAY_INVALID = 3'b010;
    localparam logic [2:0] PAY_VALID   = 3'b011;
    localparam logic [2:0] PAY_RETURN  = 3'b100;

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ARMED    = 3'd1,
        ST_DISPENSE = 3'd2,
        ST_GAP      = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    // Largest denomination not exceeding the amount, as a coin_sel code.
    function automatic logic [1:0] pick_coin(input logic [4:0] amt);
        logic [1:0] sel;
        if (amt >= 5'd10) begin
            sel = 2'b11;
        end else if (amt >= 5'd5) begin
            sel = 2'b10;
        end else if (amt >= 5'd2) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    // Unit value of a coin_sel code.
    function automatic logic [4:0] coin_value(input logic [1:0] sel);
        logic [4:0] val;
        case (sel)
            2'b00:   val = 5'd1;
            2'b01:   val = 5'd2;
            2'b10:   val = 5'd5;
            2'b11:   val = 5'd10;
            default: val = 5'd1;
        endcase
        return val;
    endfunction

    state_t             state_r, state_next_s;
    logic [4:0]         amount_left_r, amount_next_s;
    logic               refund_r, refund_next_s;
    logic               underpay_r, underpay_next_s;
    logic [1:0]         coin_sel_r, coin_next_s;
    logic [GAP_W-1:0]   gap_cnt_r, gap_next_s;
    logic               hopper_req_r, busy_r, done_r;
    logic               fault_r;
    logic               timeout_s;

`ifdef CHANGE_DISPENSER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt_r;

    // The request has been pending for its last allowed cycle without an ack.
    assign timeout_s = (state_r == ST_DISPENSE) && !hopper_ack &&
                       (to_cnt_r == TO_W'(TIMEOUT_CYCLES - 1));

    // Watchdog counter: zero outside DISPENSE, so it starts cleared on entry.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            to_cnt_r <= '0;
        end else if (state_r != ST_DISPENSE) begin
            to_cnt_r <= '0;
        end else begin
            to_cnt_r <= to_cnt_r + TO_W'(1);
        end
    end

    // Sticky fault flag, cleared only by reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fault_r <= 1'b0;
        end else if (timeout_s) begin
            fault_r <= 1'b1;
        end else begin
            fault_r <= fault_r;
        end
    end
`else
    logic unused_timeout_s;
    assign unused_timeout_s = (TIMEOUT_CYCLES > 0);
    assign timeout_s        = 1'b0;
    assign fault_r          = 1'b0;
`endif

    // Next-state and datapath updates for the payout FSM.
    always_comb begin
        state_next_s    = state_r;
        amount_next_s   = amount_left_r;
        refund_next_s   = refund_r;
        underpay_next_s = underpay_r;
        coin_next_s     = coin_sel_r;
        gap_next_s      = gap_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (pay_state == PAY_INVALID) begin
                    amount_next_s   = inputMoney;
                    refund_next_s   = 1'b1;
                    underpay_next_s = 1'b0;
                    state_next_s    = ST_ARMED;
                end else if (pay_state == PAY_VALID) begin
                    if (inputMoney >= valueToPay) begin
                        amount_next_s   = inputMoney - valueToPay;
                        refund_next_s   = 1'b0;
                        underpay_next_s = 1'b0;
                    end else begin
                        amount_next_s   = inputMoney;
                        refund_next_s   = 1'b1;
                        underpay_next_s = 1'b1;
                    end
                    state_next_s = ST_ARMED;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ARMED: begin
                if (pay_state == PAY_RETURN) begin
                    // A latched fault blocks any further hopper activity.
                    if ((amount_left_r == 5'd0) || fault_r) begin
                        state_next_s = ST_DONE;
                    end else begin
                        coin_next_s  = pick_coin(amount_left_r);
                        state_next_s = ST_DISPENSE;
                    end
                end else if (pay_state == PAY_IDLE) begin
                    amount_next_s   = 5'd0;
                    refund_next_s   = 1'b0;
                    underpay_next_s = 1'b0;
                    state_next_s    = ST_IDLE;
                end else begin
                    state_next_s = ST_ARMED;
                end
            end
            ST_DISPENSE: begin
                if (hopper_ack) begin
                    amount_next_s = amount_left_r - coin_value(coin_sel_r);
                    gap_next_s    = '0;
                    state_next_s  = ST_GAP;
                end else if (timeout_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_DISPENSE;
                end
            end
            ST_GAP: begin
                if (gap_cnt_r == GAP_W'(GAP_CYCLES - 1)) begin
                    if (amount_left_r == 5'd0) begin
                        state_next_s = ST_DONE;
                    end else begin
                        coin_next_s  = pick_coin(amount_left_r);
                        state_next_s = ST_DISPENSE;
                    end
                end else begin
                    gap_next_s = gap_cnt_r + GAP_W'(1);
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State, datapath and output registers; outputs follow the next state so
    // hopper_req and busy line up with the FSM state they describe.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            amount_left_r <= 5'd0;
            refund_r      <= 1'b0;
            underpay_r    <= 1'b0;
            coin_sel_r    <= 2'b00;
            gap_cnt_r     <= '0;
            hopper_req_r  <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            amount_left_r <= amount_next_s;
            refund_r      <= refund_next_s;
            underpay_r    <= underpay_next_s;
            coin_sel_r    <= coin_next_s;
            gap_cnt_r     <= gap_next_s;
            hopper_req_r  <= (state_next_s == ST_DISPENSE);
            busy_r        <= (state_next_s != ST_IDLE);
            done_r        <= (state_r == ST_DONE);
        end
    end

    assign hopper_req  = hopper_req_r;
    assign coin_sel    = coin_sel_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign refund      = refund_r;
    assign underpay    = underpay_r;
    assign amount_left = amount_left_r;
    assign fault       = fault_r;

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: directed cases plus randomized
// transactions compared against a transaction-level model (refund/change rule
// and greedy coin list computed with plain arithmetic).
module tb_change_dispenser;

    logic       clock = 1'b0;
    logic       reset;
    logic [2:0] pay_state;
    logic [4:0] inputMoney;
    logic [4:0] valueToPay;
    logic       hopper_ack;
    logic       hopper_req;
    logic [1:0] coin_sel;
    logic       busy;
    logic       done;
    logic       refund;
    logic       underpay;
    logic [4:0] amount_left;
    logic       fault;

    int n_checks = 0;
    int n_pass   = 0;

    change_dispenser #(.TIMEOUT_CYCLES(8), .GAP_CYCLES(1)) dut (
        .clock       (clock),
        .reset       (reset),
        .pay_state   (pay_state),
        .inputMoney  (inputMoney),
        .valueToPay  (valueToPay),
        .hopper_ack  (hopper_ack),
        .hopper_req  (hopper_req),
        .coin_sel    (coin_sel),
        .busy        (busy),
        .done        (done),
        .refund      (refund),
        .underpay    (underpay),
        .amount_left (amount_left),
        .fault       (fault)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [1:0] code_of(input int value);
        case (value)
            10:      return 2'b11;
            5:       return 2'b10;
            2:       return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    // One payment from IDLE to payout end (or abandon in ARMED).
    task automatic run_txn(input logic [2:0] code, input int money, input int price, input bit abandon);
        int exp_amt, exp_ref, exp_und, rem, k, ndone, d;
        int coins[$];
        if (code == 3'b010) begin
            exp_amt = money; exp_ref = 1; exp_und = 0;
        end else if (money >= price) begin
            exp_amt = money - price; exp_ref = 0; exp_und = 0;
        end else begin
            exp_amt = money; exp_ref = 1; exp_und = 1;
        end
        rem = exp_amt;
        while (rem > 0) begin
            int c;
            c = (rem >= 10) ? 10 : (rem >= 5) ? 5 : (rem >= 2) ? 2 : 1;
            coins.push_back(c);
            rem -= c;
        end

        pay_state = code; inputMoney = 5'(money); valueToPay = 5'(price);
        step();
        check_val("armed_busy", busy, 1);
        check_val("armed_amount", amount_left, exp_amt);
        check_val("armed_refund", refund, exp_ref);
        check_val("armed_underpay", underpay, exp_und);
        check_val("armed_req", hopper_req, 0);
        repeat ($urandom_range(0, 2)) begin
            pay_state = 3'b001;
            step();
            check_val("armed_hold", hopper_req, 0);
        end
        if (abandon) begin
            pay_state = 3'b000;
            step();
            check_val("abandon_busy", busy, 0);
            check_val("abandon_amount", amount_left, 0);
            check_val("abandon_refund", refund, 0);
            check_val("abandon_underpay", underpay, 0);
            return;
        end

        pay_state = 3'b100;
        step();
        pay_state = 3'b000;
        if (coins.size() == 0) begin
            check_val("zero_req", hopper_req, 0);
            check_val("zero_busy", busy, 1);
            check_val("zero_done_early", done, 0);
            step();
            check_val("zero_done_lat", done, 1);
            check_val("zero_busy_end", busy, 0);
            step();
            check_val("zero_done_pulse", done, 0);
            return;
        end

        rem = exp_amt;
        foreach (coins[i]) begin
            k = 0;
            while (!hopper_req && k < 20) begin
                step();
                k++;
            end
            check_val("req_wait", hopper_req, 1);
            check_val("coin_sel", coin_sel, code_of(coins[i]));
            d = $urandom_range(0, 3);
            repeat (d) begin
                step();
                check_val("req_held", hopper_req, 1);
                check_val("coin_stable", coin_sel, code_of(coins[i]));
            end
            hopper_ack = 1'b1;
            step();
            rem -= coins[i];
            check_val("gap_req", hopper_req, 0);
            check_val("amount_after_ack", amount_left, rem);
            hopper_ack = 1'($urandom_range(0, 1));
            step();
            hopper_ack = 1'b0;
        end
        ndone = 0;
        repeat (6) begin
            if (done) ndone++;
            step();
        end
        check_val("done_count", ndone, 1);
        check_val("end_amount", amount_left, 0);
        check_val("end_refund", refund, exp_ref);
        check_val("end_underpay", underpay, exp_und);
        check_val("end_busy", busy, 0);
    endtask

    initial begin
        int ndone, n;
        reset = 1'b1; pay_state = 3'b000; inputMoney = 5'd0; valueToPay = 5'd0; hopper_ack = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check_val("rst_req", hopper_req, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_amount", amount_left, 0);
        check_val("rst_coin", coin_sel, 0);
        check_val("rst_fault", fault, 0);
        reset = 1'b0;
        step();

        run_txn(3'b011, 30, 17, 1'b0);
        run_txn(3'b010, 7, 0, 1'b0);
        run_txn(3'b011, 20, 20, 1'b0);
        run_txn(3'b011, 10, 25, 1'b0);
        for (int t = 0; t < 40; t++) begin
            run_txn($urandom_range(0, 1) ? 3'b011 : 3'b010, $urandom_range(0, 31),
                    $urandom_range(0, 31), $urandom_range(0, 7) == 0);
        end

        // Reset in the middle of a handshake, with ack in the same cycle.
        pay_state = 3'b011; inputMoney = 5'd30; valueToPay = 5'd2;
        step();
        pay_state = 3'b100;
        step();
        pay_state = 3'b000;
        check_val("pre_rst_req", hopper_req, 1);
        hopper_ack = 1'b1;
        reset = 1'b1;
        #1;
        check_val("async_rst_req", hopper_req, 0);
        check_val("async_rst_busy", busy, 0);
        check_val("async_rst_amount", amount_left, 0);
        @(posedge clock);
        #1;
        reset = 1'b0; hopper_ack = 1'b0;
        ndone = 0; n = 0;
        repeat (5) begin
            step();
            if (done) ndone++;
            if (hopper_req || busy) n++;
        end
        check_val("rst_no_done", ndone, 0);
        check_val("rst_idle", n, 0);

`ifdef CHANGE_DISPENSER_TIMEOUT_EN
        pay_state = 3'b011; inputMoney = 5'd15; valueToPay = 5'd3;
        step();
        pay_state = 3'b100;
        step();
        pay_state = 3'b000;
        n = 0;
        while (hopper_req && n < 40) begin
            n++;
            step();
        end
        check_val("to_cycles", n, 8);
        check_val("to_fault", fault, 1);
        check_val("to_req", hopper_req, 0);
        check_val("to_amount", amount_left, 12);
        ndone = 0;
        repeat (4) begin
            if (done) ndone++;
            step();
        end
        check_val("to_done", ndone, 1);
        pay_state = 3'b011; inputMoney = 5'd5; valueToPay = 5'd0;
        step();
        pay_state = 3'b100;
        step();
        pay_state = 3'b000;
        n = 0; ndone = 0;
        repeat (4) begin
            if (hopper_req) n++;
            if (done) ndone++;
            step();
        end
        check_val("blocked_req", n, 0);
        check_val("blocked_done", ndone, 1);
        check_val("blocked_fault", fault, 1);
`else
        check_val("fault_tied", fault, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
